mole_game_engine: RTL

Parametrised game core for the next-generation whack-a-mole board. It replaces the fixed 16-mole, free-running game and its separate 1 Hz countdown. Provides a start/run/game-over state machine, a configurable number of moles, an LFSR-driven mole sequence, edge-based hit detection, a saturating score and an integrated game timer. Outputs feed the existing BCD / 7-segment display path and the LED bank.

---
 rtl/mole_game_pkg.sv | 17 +
 rtl/mole_lfsr.sv | 26 ++
 rtl/mole_game_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package mole_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StUp,
    StGap,
    StOver
  } state_e;

  localparam int unsigned LfsrWidth = 16;
  // Galois right-shift form of taps 16,14,13,11.
  localparam logic [LfsrWidth-1:0] LfsrTaps = 16'hB400;
  localparam logic [LfsrWidth-1:0] DefaultLfsrSeed = 16'hACE1;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every cycle, reloads the seed on reset.
module mole_lfsr
  import mole_game_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] LFSR_SEED = DefaultLfsrSeed
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [LfsrWidth-1:0] lfsr
);

  logic [LfsrWidth-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LfsrTaps;
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole game core: switch synchroniser, game timer, mole FSM and score.
// Optional MOLE_MISS_PENALTY_EN: wrong-switch toggles and timeouts cost one point.
module mole_game_engine
  import mole_game_pkg::*;
#(
  parameter int unsigned          N_MOLES          = 16,
  parameter int unsigned          SCORE_BITS       = 8,
  parameter int unsigned          TIME_BITS        = 8,
  parameter int unsigned          GAME_SECONDS     = 30,
  parameter int unsigned          SEC_DIV          = 100_000_000,
  parameter int unsigned          MOLE_LIFE_CYCLES = 75_000_000,
  parameter int unsigned          GAP_CYCLES       = 25_000_000,
  parameter logic [LfsrWidth-1:0] LFSR_SEED        = DefaultLfsrSeed
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_MOLES-1:0]    sw,
  output logic [N_MOLES-1:0]    LED,
  output logic [SCORE_BITS-1:0] score,
  output logic [TIME_BITS-1:0]  time_left,
  output logic                  running,
  output logic                  game_over
);

  localparam int unsigned IdxW = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;

  logic [LfsrWidth-1:0]  lfsr;
  logic [N_MOLES-1:0]    sw_meta_q, sw_sync_q, sw_prev_q, toggle;
  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d, raw_idx, spawn_idx;
  logic [31:0]           life_q, life_d, gap_q, gap_d, presc_q, presc_d;
  logic [TIME_BITS-1:0]  time_q, time_d;
  logic [SCORE_BITS-1:0] score_q, score_d;
  logic [N_MOLES-1:0]    led_q, led_d;
  logic                  running_q, running_d, game_over_q, game_over_d;
  logic                  in_play;

  mole_lfsr #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .lfsr (lfsr)
  );

  assign toggle  = sw_sync_q ^ sw_prev_q;
  assign in_play = (state_q == StSpawn) || (state_q == StUp) || (state_q == StGap);

  // Never light the same mole twice in a row.
  always_comb begin
    raw_idx   = IdxW'(32'(lfsr) % N_MOLES);
    spawn_idx = raw_idx;
    if (raw_idx == idx_q) begin
      spawn_idx = (raw_idx == IdxW'(N_MOLES - 1)) ? '0 : raw_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    life_d  = life_q;
    gap_d   = gap_q;
    presc_d = presc_q;
    time_d  = time_q;
    score_d = score_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d = StSpawn;
          score_d = '0;
          time_d  = TIME_BITS'(GAME_SECONDS);
          presc_d = '0;
        end
      end
      StSpawn: begin
        idx_d   = spawn_idx;
        life_d  = MOLE_LIFE_CYCLES - 1;
        state_d = StUp;
      end
      StUp: begin
        // A hit on the lit mole wins over any other toggle or a same-cycle expiry.
        if (toggle[idx_q]) begin
          if (score_q != '1) score_d = score_q + 1'b1;
          state_d = StGap;
          gap_d   = GAP_CYCLES - 1;
        end else begin
`ifdef MOLE_MISS_PENALTY_EN
          if ((((toggle & ~led_q) != '0) || (life_q == '0)) && (score_q != '0)) begin
            score_d = score_q - 1'b1;
          end
`endif
          if (life_q == '0) begin
            state_d = StGap;
            gap_d   = GAP_CYCLES - 1;
          end else begin
            life_d = life_q - 1;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StSpawn;
        else             gap_d   = gap_q - 1;
      end
      default: state_d = StIdle;
    endcase

    // Timer expiry overrides whatever the FSM decided this cycle.
    if (in_play) begin
      if (presc_q == SEC_DIV - 1) begin
        presc_d = '0;
        time_d  = time_q - 1'b1;
        if (time_q == TIME_BITS'(1)) state_d = StOver;
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end

    led_d = '0;
    if (state_d == StUp) led_d[idx_d] = 1'b1;
    running_d   = (state_d == StSpawn) || (state_d == StUp) || (state_d == StGap);
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_prev_q   <= '0;
      state_q     <= StIdle;
      idx_q       <= '0;
      life_q      <= '0;
      gap_q       <= '0;
      presc_q     <= '0;
      time_q      <= TIME_BITS'(GAME_SECONDS);
      score_q     <= '0;
      led_q       <= '0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
      sw_prev_q   <= sw_sync_q;
      state_q     <= state_d;
      idx_q       <= idx_d;
      life_q      <= life_d;
      gap_q       <= gap_d;
      presc_q     <= presc_d;
      time_q      <= time_d;
      score_q     <= score_d;
      led_q       <= led_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  assign LED       = led_q;
  assign score     = score_q;
  assign time_left = time_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule
